// File: rtl/if_id_stage.sv
// IF/ID pipeline register: 1-cycle latency; stall_i holds, mem_stall_i freezes and defers flushes, flush_i bubbles.
// Optional saturating stall/flush performance counters under macro IF_ID_PERF_EN.
module if_id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             mem_stall_i,
  input  logic             flush_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      instr_o,
  output logic             valid_o,
  output logic             flush_pend_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        flush_pend_q, flush_pend_d;
  logic        do_flush;

  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    do_flush     = 1'b0;
    if (mem_stall_i) begin
      // Frozen: remember any flush so it lands on the first unfrozen edge.
      flush_pend_d = flush_pend_q | flush_i;
    end else if (flush_i || flush_pend_q) begin
      pc_d         = PC_RESET;
      instr_d      = NOP_INSTR;
      valid_d      = 1'b0;
      flush_pend_d = 1'b0;
      do_flush     = 1'b1;
    end else if (!stall_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q         <= PC_RESET;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign pc_o         = pc_q;
  assign instr_o      = instr_q;
  assign valid_o      = valid_q;
  assign flush_pend_o = flush_pend_q;

`ifdef IF_ID_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((stall_i || mem_stall_i) && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (do_flush && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  logic unused_flush;
  assign unused_flush = do_flush;
  assign stall_cnt_o  = '0;
  assign flush_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage; counter expectations follow whether IF_ID_PERF_EN is defined.
module tb_if_id_stage;

`ifdef IF_ID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, stall, mem_stall, flush;
  logic [31:0]   pc_in, instr_in;
  logic [31:0]   pc_out, instr_out;
  logic          valid_out, fp_out;
  logic [CW-1:0] scnt, fcnt;

  int n_assert = 0;
  int n_fail   = 0;

  if_id_stage #(.CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .mem_stall_i(mem_stall),
    .flush_i(flush), .pc_i(pc_in), .instr_i(instr_in),
    .pc_o(pc_out), .instr_o(instr_out), .valid_o(valid_out),
    .flush_pend_o(fp_out), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic v, input logic fp);
    chk({tag, ".pc"}, pc_out, pc);
    chk({tag, ".instr"}, instr_out, ins);
    chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
    chk({tag, ".fpend"}, {31'd0, fp_out}, {31'd0, fp});
  endtask

  task automatic chk_cnt(input string tag, input int s, input int f);
    logic [CW-1:0] es, ef;
    es = PERF ? CW'(s) : '0;
    ef = PERF ? CW'(f) : '0;
    chk({tag, ".stall_cnt"}, {28'd0, scnt}, {28'd0, es});
    chk({tag, ".flush_cnt"}, {28'd0, fcnt}, {28'd0, ef});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; mem_stall = 1'b0; flush = 1'b0;
    pc_in = 32'h0000_0040; instr_in = 32'hDEAD_BEEF;

    // T1 reset
    tick(); tick();
    chk_out("rst", 32'h0, 32'h13, 1'b0, 1'b0);
    chk_cnt("rst", 0, 0);
    rst = 1'b0; stall = 1'b1;
    tick();
    chk_out("t1_stall", 32'h0, 32'h13, 1'b0, 1'b0);
    chk_cnt("t1", 1, 0);

    // T2 normal flow
    stall = 1'b0; pc_in = 32'h04; instr_in = 32'h00A0_0093;
    tick();
    chk_out("t2", 32'h04, 32'h00A0_0093, 1'b1, 1'b0);

    // T3 hazard stall
    pc_in = 32'h08; instr_in = 32'h0020_A103;
    tick();
    chk_out("t3_load", 32'h08, 32'h0020_A103, 1'b1, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'h100 + i; instr_in = 32'h1111_0000 + i;
      tick();
      chk_out("t3_hold", 32'h08, 32'h0020_A103, 1'b1, 1'b0);
    end
    chk_cnt("t3", 4, 0);

    // T4 flush beats stall
    flush = 1'b1;
    tick();
    chk_out("t4", 32'h0, 32'h13, 1'b0, 1'b0);
    chk_cnt("t4", 5, 1);
    stall = 1'b0; flush = 1'b0; pc_in = 32'h0C; instr_in = 32'h0050_0113;
    tick();
    chk_out("t4_resume", 32'h0C, 32'h0050_0113, 1'b1, 1'b0);

    // T5 deferred flush across a 5-cycle mem stall, two pulses, stall_i overlap at the end
    mem_stall = 1'b1; pc_in = 32'h10; instr_in = 32'hAAAA_0001;
    tick();
    chk_out("t5_c1", 32'h0C, 32'h0050_0113, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    chk_out("t5_c2", 32'h0C, 32'h0050_0113, 1'b1, 1'b1);
    flush = 1'b0;
    tick();
    chk_out("t5_c3", 32'h0C, 32'h0050_0113, 1'b1, 1'b1);
    flush = 1'b1;
    tick();
    chk_out("t5_c4", 32'h0C, 32'h0050_0113, 1'b1, 1'b1);
    flush = 1'b0; stall = 1'b1;
    tick();
    chk_out("t5_c5", 32'h0C, 32'h0050_0113, 1'b1, 1'b1);
    chk_cnt("t5_stall", 10, 1);
    mem_stall = 1'b0; stall = 1'b0; pc_in = 32'h20; instr_in = 32'h0010_0193;
    tick();
    chk_out("t5_bubble", 32'h0, 32'h13, 1'b0, 1'b0);
    chk_cnt("t5_bubble", 10, 2);
    tick();
    chk_out("t5_single", 32'h20, 32'h0010_0193, 1'b1, 1'b0);

    // Reset with a pending flush discards it
    mem_stall = 1'b1; flush = 1'b1;
    tick();
    chk_out("rp_pend", 32'h20, 32'h0010_0193, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    chk_out("rp_rst", 32'h0, 32'h13, 1'b0, 1'b0);
    chk_cnt("rp_rst", 0, 0);
    rst = 1'b0; mem_stall = 1'b0; flush = 1'b0; pc_in = 32'h24; instr_in = 32'h0020_8233;
    tick();
    chk_out("rp_after", 32'h24, 32'h0020_8233, 1'b1, 1'b0);

    // T6 saturation of the 4-bit stall counter
    stall = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk_cnt("t6_14", 14, 0);
    tick();
    chk_cnt("t6_15", 15, 0);
    for (int i = 0; i < 5; i++) tick();
    chk_cnt("t6_20", 15, 0);
    chk_out("t6_hold", 32'h24, 32'h0020_8233, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
